// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jtag_pkg
//  Brief    : Shared JTAG data-path constants and receiver state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package jtag_pkg;

  localparam int DEFAULT_WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_FULL  = 2'd2
  } rx_state_t;

endpackage : jtag_pkg
`default_nettype wire

// File: rtl/word_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : word_receiver
//  Brief    : JTAG TDI serial-to-parallel word receiver. Samples 'in' on each
//             TCK rising edge while Shift-DR (enable) is high and presents the
//             completed WIDTH-bit word with a one-cycle valid pulse. Flags
//             over-length frames (sticky overflow) and truncated frames
//             (one-cycle aborted pulse).
//  Config   : WORD_RECEIVER_LSB_FIRST_EN - when defined the first received
//             bit lands in data[0] (right-shift in); default is MSB-first.
//  Revision : 1.0 - initial release
// ============================================================================
module word_receiver
  import jtag_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WORD_WIDTH,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             in,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [CW-1:0]    bit_count,
  output logic             overflow,
  output logic             aborted
);

  localparam logic [CW-1:0] C_LAST_IDX = CW'(WIDTH - 1);

  rx_state_t        r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_aborted;

  rx_state_t        w_state_nxt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_valid_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic             w_overflow_nxt;
  logic             w_aborted_nxt;
  logic [WIDTH-1:0] w_shifted;

  // Shift register with the current serial bit inserted at the configured end
`ifdef WORD_RECEIVER_LSB_FIRST_EN
  assign w_shifted = {in, r_shift[WIDTH-1:1]};
`else
  assign w_shifted = {r_shift[WIDTH-2:0], in};
`endif

  // Next-state, counter, flag and word-capture decisions for the frame FSM
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_data_nxt     = r_data;
    w_valid_nxt    = 1'b0;
    w_count_nxt    = r_count;
    w_overflow_nxt = r_overflow;
    w_aborted_nxt  = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (enable) begin
          // A new frame starts: first bit accepted, stale overflow dropped
          w_shift_nxt    = w_shifted;
          w_count_nxt    = CW'(1);
          w_overflow_nxt = 1'b0;
          w_state_nxt    = RX_SHIFT;
        end
      end
      RX_SHIFT: begin
        if (enable) begin
          w_shift_nxt = w_shifted;
          w_count_nxt = r_count + CW'(1);
          if (r_count == C_LAST_IDX) begin
            w_data_nxt  = w_shifted;
            w_valid_nxt = 1'b1;
            w_state_nxt = RX_FULL;
          end
        end else begin
          // Count is always below WIDTH here, so the frame is truncated
          w_aborted_nxt = 1'b1;
          w_count_nxt   = '0;
          w_state_nxt   = RX_IDLE;
        end
      end
      RX_FULL: begin
        if (enable) begin
          w_overflow_nxt = 1'b1;
        end else begin
          w_count_nxt = '0;
          w_state_nxt = RX_IDLE;
        end
      end
      default: begin
        w_count_nxt = '0;
        w_state_nxt = RX_IDLE;
      end
    endcase
  end

  // Register shift register, counter, output word, flags and FSM state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= RX_IDLE;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_aborted  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_data     <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_count    <= w_count_nxt;
      r_overflow <= w_overflow_nxt;
      r_aborted  <= w_aborted_nxt;
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign bit_count = r_count;
  assign overflow  = r_overflow;
  assign aborted   = r_aborted;

endmodule : word_receiver
`default_nettype wire

// File: tb/tb_word_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_word_receiver
//  Brief    : Directed self-checking bench for word_receiver (WIDTH = 32).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_word_receiver;

  localparam int WIDTH = 32;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk;
  logic             reset_n;
  logic             enable;
  logic             din;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic [CW-1:0]    bit_count;
  logic             overflow;
  logic             aborted;

  int tests_run;
  int tests_failed;
  logic [WIDTH-1:0] last_word;

  word_receiver #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .in        (din),
    .data      (data),
    .valid     (valid),
    .bit_count (bit_count),
    .overflow  (overflow),
    .aborted   (aborted)
  );

  // 10 ns TCK
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net against a stalled run
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (actual running, required finished)");
    $fatal(1, "timeout");
  end

  // Word expected in data after sending w serially MSB-first
  function automatic logic [WIDTH-1:0] exp_word(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
`ifdef WORD_RECEIVER_LSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) r[i] = w[WIDTH-1-i];
`else
    r = w;
`endif
    return r;
  endfunction

  // Advance one edge and move to a sampling point away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shift nbits of w (MSB-first, zeros beyond WIDTH); reports valid pulses
  task automatic send_bits(input logic [WIDTH-1:0] w, input int nbits,
                           output int nvalid, output int valid_at,
                           output int naborted);
    nvalid = 0; valid_at = -1; naborted = 0;
    for (int i = 0; i < nbits; i++) begin
      enable = 1'b1;
      din    = (i < WIDTH) ? w[WIDTH-1-i] : 1'b0;
      tick();
      if (valid) begin nvalid++; valid_at = i; end
      if (aborted) naborted++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; din = 1'b0;
    #3;
    tests_run++;
    if (data !== '0 || valid !== 1'b0 || bit_count !== '0 ||
        overflow !== 1'b0 || aborted !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: data=%h valid=%b cnt=%0d ovf=%b abt=%b, required all zero",
               data, valid, bit_count, overflow, aborted);
    end
    tick(); tick();
    reset_n = 1'b1;
    tick();
    tests_run++;
    if (valid !== 1'b0 || bit_count !== '0) begin
      tests_failed++;
      $display("FAIL reset_idle: valid=%b cnt=%0d, required 0/0", valid, bit_count);
    end
  endtask

  task automatic test_full_frame();
    int nv, va, na;
    enable = 1'b1; din = 1'b1;
    tick();
    tests_run++;
    if (bit_count !== CW'(1)) begin
      tests_failed++;
      $display("FAIL first_bit_count: got %0d, required 1", bit_count);
    end
    // Bit 0 (MSB of 0xDEADBEEF = 1) already sent; finish the other 31
    nv = 0; va = -1; na = 0;
    for (int i = 1; i < WIDTH; i++) begin
      din = (32'hDEADBEEF >> (WIDTH-1-i)) & 1;
      tick();
      if (valid) begin nv++; va = i; end
      if (aborted) na++;
    end
    tests_run++;
    if (nv != 1 || va != WIDTH-1) begin
      tests_failed++;
      $display("FAIL full_valid_pulse: pulses=%0d at bit %0d, required 1 at bit %0d", nv, va, WIDTH-1);
    end
    tests_run++;
    if (data !== exp_word(32'hDEADBEEF) || bit_count !== CW'(WIDTH) || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_data: data=%h cnt=%0d ovf=%b, required %h 32 0",
               data, bit_count, overflow, exp_word(32'hDEADBEEF));
    end
    enable = 1'b0;
    tick();
    tests_run++;
    if (valid !== 1'b0 || aborted !== 1'b0 || bit_count !== '0 || na != 0 ||
        data !== exp_word(32'hDEADBEEF)) begin
      tests_failed++;
      $display("FAIL full_end: valid=%b abt=%b(%0d) cnt=%0d data=%h, required 0 0 0 %h",
               valid, aborted, na, bit_count, data, exp_word(32'hDEADBEEF));
    end
    last_word = exp_word(32'hDEADBEEF);
  endtask

  task automatic test_truncated();
    int nv, va, na;
    send_bits(32'h9ABC_0000, 12, nv, va, na);
    tests_run++;
    if (bit_count !== CW'(12) || nv != 0) begin
      tests_failed++;
      $display("FAIL trunc_count: cnt=%0d valid_pulses=%0d, required 12 0", bit_count, nv);
    end
    enable = 1'b0;
    tick();
    tests_run++;
    if (aborted !== 1'b1 || valid !== 1'b0 || data !== last_word || bit_count !== '0) begin
      tests_failed++;
      $display("FAIL trunc_abort: abt=%b valid=%b data=%h cnt=%0d, required 1 0 %h 0",
               aborted, valid, data, bit_count, last_word);
    end
    tick();
    tests_run++;
    if (aborted !== 1'b0 || data !== last_word) begin
      tests_failed++;
      $display("FAIL trunc_pulse_width: abt=%b data=%h, required 0 %h", aborted, data, last_word);
    end
  endtask

  task automatic test_overlength();
    int nv, va, na;
    send_bits(32'hA5A5_0F0F, WIDTH, nv, va, na);
    tests_run++;
    if (nv != 1 || va != WIDTH-1 || data !== exp_word(32'hA5A5_0F0F)) begin
      tests_failed++;
      $display("FAIL over_word: pulses=%0d at %0d data=%h, required 1 at 31 %h",
               nv, va, data, exp_word(32'hA5A5_0F0F));
    end
    enable = 1'b1; din = 1'b1;
    tick();
    tests_run++;
    if (overflow !== 1'b1 || valid !== 1'b0 || bit_count !== CW'(WIDTH)) begin
      tests_failed++;
      $display("FAIL over_bit33: ovf=%b valid=%b cnt=%0d, required 1 0 32", overflow, valid, bit_count);
    end
    din = 1'b0; tick();
    din = 1'b1; tick();
    tests_run++;
    if (overflow !== 1'b1 || bit_count !== CW'(WIDTH) || data !== exp_word(32'hA5A5_0F0F) ||
        valid !== 1'b0 || aborted !== 1'b0) begin
      tests_failed++;
      $display("FAIL over_bit35: ovf=%b cnt=%0d data=%h valid=%b abt=%b, required 1 32 %h 0 0",
               overflow, bit_count, data, valid, aborted, exp_word(32'hA5A5_0F0F));
    end
    enable = 1'b0;
    tick();
    tests_run++;
    if (aborted !== 1'b0 || bit_count !== '0 || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL over_end: abt=%b cnt=%0d ovf=%b, required 0 0 1", aborted, bit_count, overflow);
    end
  endtask

  task automatic test_back_to_back();
    int nv, va, na;
    enable = 1'b1; din = 1'b0;  // MSB of 0x12345678
    tick();
    tests_run++;
    if (overflow !== 1'b0 || bit_count !== CW'(1)) begin
      tests_failed++;
      $display("FAIL b2b_ovf_clear: ovf=%b cnt=%0d, required 0 1", overflow, bit_count);
    end
    nv = 0; na = 0;
    for (int i = 1; i < WIDTH; i++) begin
      din = (32'h12345678 >> (WIDTH-1-i)) & 1;
      tick();
      if (valid) nv++;
    end
    tests_run++;
    if (nv != 1 || data !== exp_word(32'h12345678)) begin
      tests_failed++;
      $display("FAIL b2b_first: pulses=%0d data=%h, required 1 %h", nv, data, exp_word(32'h12345678));
    end
    enable = 1'b0;
    tick();
    send_bits(32'hCAFEF00D, WIDTH, nv, va, na);
    tests_run++;
    if (nv != 1 || va != WIDTH-1 || na != 0 || data !== exp_word(32'hCAFEF00D)) begin
      tests_failed++;
      $display("FAIL b2b_second: pulses=%0d at %0d abt=%0d data=%h, required 1 at 31 0 %h",
               nv, va, na, data, exp_word(32'hCAFEF00D));
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_reset_midframe();
    int nv, va, na;
    send_bits(32'h5555_AAAA, 20, nv, va, na);
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (data !== '0 || valid !== 1'b0 || bit_count !== '0 ||
        overflow !== 1'b0 || aborted !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_clear: data=%h valid=%b cnt=%0d ovf=%b abt=%b, required all zero",
               data, valid, bit_count, overflow, aborted);
    end
    enable = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    tests_run++;
    if (valid !== 1'b0 || aborted !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_pulse: valid=%b abt=%b, required 0 0", valid, aborted);
    end
    send_bits(32'h0F1E2D3C, WIDTH, nv, va, na);
    tests_run++;
    if (nv != 1 || va != WIDTH-1 || data !== exp_word(32'h0F1E2D3C)) begin
      tests_failed++;
      $display("FAIL midreset_frame: pulses=%0d at %0d data=%h, required 1 at 31 %h",
               nv, va, data, exp_word(32'h0F1E2D3C));
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_shift_order();
    int nv, va, na;
    logic [WIDTH-1:0] req;
`ifdef WORD_RECEIVER_LSB_FIRST_EN
    req = 32'h8000_0000;
`else
    req = 32'h0000_0001;
`endif
    send_bits(32'h0000_0001, WIDTH, nv, va, na);
    tests_run++;
    if (nv != 1 || data !== req) begin
      tests_failed++;
      $display("FAIL shift_order: pulses=%0d data=%h, required 1 %h", nv, data, req);
    end
    enable = 1'b0;
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    last_word    = '0;
    test_reset();
    test_full_frame();
    test_truncated();
    test_overlength();
    test_back_to_back();
    test_reset_midframe();
    test_shift_order();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_word_receiver
`default_nettype wire
